tour_cmd: RTL and testbench
===========================

Name: tour_cmd

Overview:
Sits between the UART command path and cmd_proc, directly upstream of cmd_proc. In UART mode it passes host commands, such as 0x2000 calibrate and 0x6xxx tour, straight through to cmd_proc. After the tour solver finishes and pulses start_tour, it replays the stored knight's tour as move commands. Each knight move becomes two commands: a vertical leg, then a horizontal leg with fanfare. It also generates the response byte returned to the remote.

Parameters:
NUM_MOVES, 24, number of knight moves in a full tour (5x5 board, 25 squares)
IDX_W, 5, width of mv_indx; must satisfy 2^IDX_W >= NUM_MOVES

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start_tour  in  1  one-cycle pulse from tour solver: move table is valid, begin replay
move  in  8  one-hot knight move read from the solver table at mv_indx
mv_indx  out  IDX_W  index of the move currently being replayed
cmd_UART  in  16  command assembled by the UART wrapper
cmd_rdy_UART  in  1  cmd_UART valid
clr_cmd_rdy_UART  out  1  clears cmd_rdy_UART in the UART wrapper
cmd  out  16  command presented to cmd_proc
cmd_rdy  out  1  cmd valid to cmd_proc
clr_cmd_rdy  in  1  cmd_proc has consumed cmd
send_resp  in  1  cmd_proc has finished executing the command
resp  out  8  response byte: 0xA5 = done/ack, 0x5A = tour move in progress

Behaviour:
- Command format: [15:12] opcode, [11:4] heading, [3:0] squares.
  - Opcodes: 4'h4 = move, 4'h5 = move with fanfare.
  - Headings: N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
- Move decode: vertical leg uses opcode 4'h4; horizontal leg uses opcode 4'h5.
  - bit0: N2, E1 (0x4002, 0x5BF1)
  - bit1: N2, W1 (0x4002, 0x53F1)
  - bit2: N1, W2 (0x4001, 0x53F2)
  - bit3: S1, W2 (0x47F1, 0x53F2)
  - bit4: S2, W1 (0x47F2, 0x53F1)
  - bit5: S2, E1 (0x47F2, 0x5BF1)
  - bit6: S1, E2 (0x47F1, 0x5BF2)
  - bit7: N1, E2 (0x4001, 0x5BF2)
- Move priority: if move is not one-hot, the lowest set bit wins. If move is all-zero, emit 0x4000 then 0x5000 (zero-square legs).
- Modes: a mode flop selects UART or TOUR; reset sets UART.
- UART mode outputs:
  - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy.
  - resp = 0xA5.
- TOUR mode outputs:
  - cmd and cmd_rdy come from the FSM.
  - clr_cmd_rdy_UART = 0; cmd_rdy_UART is ignored and left pending.
- FSM states: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: on start_tour, clear mv_indx to 0, set mode = TOUR, go to VERT.
  - VERT: cmd = vertical leg of move, cmd_rdy = 1. On clr_cmd_rdy, go to WAIT_V.
  - WAIT_V: cmd_rdy = 0, cmd holds the vertical command. On send_resp, go to HORZ.
  - HORZ: cmd = horizontal leg, cmd_rdy = 1. On clr_cmd_rdy, go to WAIT_H.
  - WAIT_H: cmd_rdy = 0. On send_resp:
    - if mv_indx == NUM_MOVES-1: go to IDLE and set mode = UART;
    - else: mv_indx++ and go to VERT.
- cmd and cmd_rdy are combinational from state, mode and move.
  - Latency: start_tour sampled at edge N gives cmd_rdy = 1 with the vertical command during cycle N+1.
- Responses:
  - resp = 0x5A in TOUR mode.
  - resp = 0xA5 in WAIT_H when mv_indx == NUM_MOVES-1, i.e. the final leg.
  - resp = 0xA5 in UART mode.
- Boundary conditions:
  - start_tour outside IDLE is ignored.
  - clr_cmd_rdy in WAIT_V or WAIT_H is ignored.
  - send_resp in VERT or HORZ is ignored.
  - clr_cmd_rdy and send_resp in the same cycle: only the one valid for the current state acts; the other is dropped.
  - mv_indx never exceeds NUM_MOVES-1 and never wraps.
- Reset (synchronous, any time, including mid-tour) sets:
  - state = IDLE, mode = UART, mv_indx = 0;
  - outputs revert to UART passthrough, so with cmd_rdy_UART = 0: cmd_rdy = 0, clr_cmd_rdy_UART = 0, resp = 0xA5.

Test Plan:
- UART passthrough: cmd_UART = 0x2000 with cmd_rdy_UART = 1, then pulse clr_cmd_rdy -> cmd = 0x2000, cmd_rdy = 1, clr_cmd_rdy_UART pulses the same cycle, resp = 0xA5, mv_indx = 0.
- Single move decode: move = 8'h01, pulse start_tour -> next cycle cmd = 0x4002, cmd_rdy = 1.
  - Then clr_cmd_rdy -> cmd_rdy = 0.
  - Then send_resp -> cmd = 0x5BF1, cmd_rdy = 1, resp = 0x5A.
- Full tour: model cmd_proc with a 3-cycle clr_cmd_rdy and 20-cycle send_resp, and cycle the table through all 8 move codes -> exactly 48 commands matching the decode table.
  - mv_indx steps 0..23.
  - resp = 0xA5 only on the 48th send_resp; then mode returns to UART.
- Handshake abuse: send_resp during VERT, clr_cmd_rdy during WAIT_V, and start_tour mid-tour -> no state change, mv_indx unchanged.
  - Pending cmd_rdy_UART stays high, with clr_cmd_rdy_UART = 0 throughout the tour.
- Reset mid-tour: rst_n low in HORZ at mv_indx = 7 -> next edge gives mv_indx = 0, cmd_rdy = 0, UART passthrough restored.
  - A new start_tour then restarts from mv_indx = 0.
- Bad move encodings: move = 8'h00 -> 0x4000 then 0x5000; move = 8'h0C -> decoded as bit2 (0x4001, 0x53F2).

Source files
------------

// File: rtl/tour_cmd.sv
// Purpose: muxes UART commands to cmd_proc, or replays the solved knight's tour as vertical/horizontal move pairs.
// Latency: cmd/cmd_rdy are combinational; start_tour at edge N presents the first vertical leg during cycle N+1.
// Backpressure: each leg is held until clr_cmd_rdy, and the next leg waits for send_resp; UART commands stay pending during a tour.
module tour_cmd #(
    parameter int NUM_MOVES = 24,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_tour,
    input  logic [7:0]       move,
    output logic [IDX_W-1:0] mv_indx,
    input  logic [15:0]      cmd_UART,
    input  logic             cmd_rdy_UART,
    output logic             clr_cmd_rdy_UART,
    output logic [15:0]      cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic             send_resp,
    output logic [7:0]       resp
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] VERT   = 3'd1;
    localparam logic [2:0] WAIT_V = 3'd2;
    localparam logic [2:0] HORZ   = 3'd3;
    localparam logic [2:0] WAIT_H = 3'd4;

    localparam logic MODE_UART = 1'b0;
    localparam logic MODE_TOUR = 1'b1;

    localparam logic [3:0] OP_MOVE = 4'h4;
    localparam logic [3:0] OP_FANF = 4'h5;
    localparam logic [7:0] HDG_N   = 8'h00;
    localparam logic [7:0] HDG_W   = 8'h3F;
    localparam logic [7:0] HDG_S   = 8'h7F;
    localparam logic [7:0] HDG_E   = 8'hBF;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    logic [2:0]  state;
    logic        mode;
    logic        last_move;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;

    assign last_move = (mv_indx == LAST_IDX);

    // Decode the one-hot knight move into its two legs; the if-chain makes the lowest set bit win
    always_comb begin
        vert_cmd = {OP_MOVE, HDG_N, 4'd0};
        horz_cmd = {OP_FANF, HDG_N, 4'd0};
        if (move[0]) begin
            vert_cmd = {OP_MOVE, HDG_N, 4'd2};
            horz_cmd = {OP_FANF, HDG_E, 4'd1};
        end else if (move[1]) begin
            vert_cmd = {OP_MOVE, HDG_N, 4'd2};
            horz_cmd = {OP_FANF, HDG_W, 4'd1};
        end else if (move[2]) begin
            vert_cmd = {OP_MOVE, HDG_N, 4'd1};
            horz_cmd = {OP_FANF, HDG_W, 4'd2};
        end else if (move[3]) begin
            vert_cmd = {OP_MOVE, HDG_S, 4'd1};
            horz_cmd = {OP_FANF, HDG_W, 4'd2};
        end else if (move[4]) begin
            vert_cmd = {OP_MOVE, HDG_S, 4'd2};
            horz_cmd = {OP_FANF, HDG_W, 4'd1};
        end else if (move[5]) begin
            vert_cmd = {OP_MOVE, HDG_S, 4'd2};
            horz_cmd = {OP_FANF, HDG_E, 4'd1};
        end else if (move[6]) begin
            vert_cmd = {OP_MOVE, HDG_S, 4'd1};
            horz_cmd = {OP_FANF, HDG_E, 4'd2};
        end else if (move[7]) begin
            vert_cmd = {OP_MOVE, HDG_N, 4'd1};
            horz_cmd = {OP_FANF, HDG_E, 4'd2};
        end
    end

    // Output mux: UART passthrough by default, FSM-driven legs while touring
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_ACK;
        if (mode == MODE_TOUR) begin
            clr_cmd_rdy_UART = 1'b0;
            resp             = (state == WAIT_H && last_move) ? RESP_ACK : RESP_BUSY;
            case (state)
                VERT: begin
                    cmd     = vert_cmd;
                    cmd_rdy = 1'b1;
                end
                HORZ: begin
                    cmd     = horz_cmd;
                    cmd_rdy = 1'b1;
                end
                WAIT_H: begin
                    cmd     = horz_cmd;
                    cmd_rdy = 1'b0;
                end
                default: begin
                    cmd     = vert_cmd;
                    cmd_rdy = 1'b0;
                end
            endcase
        end
    end

    // Tour sequencer: each state reacts only to the handshake that is meaningful in it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode    <= MODE_UART;
            mv_indx <= '0;
        end else begin
            case (state)
                IDLE: if (start_tour) begin
                    mv_indx <= '0;
                    mode    <= MODE_TOUR;
                    state   <= VERT;
                end
                VERT:   if (clr_cmd_rdy) state <= WAIT_V;
                WAIT_V: if (send_resp)   state <= HORZ;
                HORZ:   if (clr_cmd_rdy) state <= WAIT_H;
                WAIT_H: if (send_resp) begin
                    if (last_move) begin
                        state <= IDLE;
                        mode  <= MODE_UART;
                    end else begin
                        mv_indx <= mv_indx + IDX_W'(1);
                        state   <= VERT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Purpose: self-checking bench for tour_cmd with a cmd_proc model and a command scoreboard.
// Latency: outputs are sampled on the falling edge, inputs change on the falling edge.
// Backpressure: cmd_proc model acks a leg a few cycles after cmd_rdy and responds ~20 cycles later.
module tb_tour_cmd;

    localparam int NUM_MOVES = 24;
    localparam int IDX_W     = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic             clr_cmd_rdy_UART;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [7:0]       resp;

    int errors = 0;
    int checks = 0;
    int leak   = 0;
    logic mon_en = 1'b0;
    logic [7:0]  tbl [0:31];
    logic [15:0] exp_q [$];

    tour_cmd #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
    );

    always #5 clk = ~clk;

    // Solver move table read at the replay index
    always_comb move = tbl[mv_indx];

    // UART clear must never leak out while a tour is running
    always @(negedge clk) if (mon_en && clr_cmd_rdy_UART !== 1'b0) leak++;

    // Reference decode: lowest set bit selects the legs
    function automatic logic [15:0] model_cmd(input logic [7:0] m, input bit horz);
        int k;
        k = -1;
        for (int i = 7; i >= 0; i--) if (m[i]) k = i;
        case (k)
            0: return horz ? 16'h5BF1 : 16'h4002;
            1: return horz ? 16'h53F1 : 16'h4002;
            2: return horz ? 16'h53F2 : 16'h4001;
            3: return horz ? 16'h53F2 : 16'h47F1;
            4: return horz ? 16'h53F1 : 16'h47F2;
            5: return horz ? 16'h5BF1 : 16'h47F2;
            6: return horz ? 16'h5BF2 : 16'h47F1;
            7: return horz ? 16'h5BF2 : 16'h4001;
            default: return horz ? 16'h5000 : 16'h4000;
        endcase
    endfunction

    task automatic fill_table(input bool_walk, input logic [7:0] val);
        for (int i = 0; i < 32; i++) tbl[i] = bool_walk ? (8'h01 << (i % 8)) : val;
    endtask

    task automatic push_move(input logic [7:0] m);
        exp_q.push_back(model_cmd(m, 1'b0));
        exp_q.push_back(model_cmd(m, 1'b1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
    endtask

    // Models cmd_proc for one leg: wait for cmd_rdy, score cmd, ack after 3 cycles, respond after ~20
    task automatic serve_leg(input string nm, input logic [IDX_W-1:0] exp_idx, input logic [7:0] exp_resp);
        int n;
        logic [15:0] exp;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s cmd_rdy_timeout: got cmd_rdy=%b want 1 within 100 cycles", nm, cmd_rdy);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        checks++;
        if (cmd !== exp) begin
            errors++;
            $display("FAIL %s cmd: got %h want %h (mv_indx=%0d)", nm, cmd, exp, mv_indx);
        end
        checks++;
        if (mv_indx !== exp_idx) begin
            errors++;
            $display("FAIL %s mv_indx: got %0d want %0d", nm, mv_indx, exp_idx);
        end
        repeat (2) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s cmd_rdy_drop: got %b want 0", nm, cmd_rdy);
        end
        repeat (18) @(negedge clk);
        checks++;
        if (resp !== exp_resp) begin
            errors++;
            $display("FAIL %s resp: got %h want %h (mv_indx=%0d)", nm, resp, exp_resp, mv_indx);
        end
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic test_reset();
        cmd_rdy_UART = 1'b0;
        do_reset();
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset cmd_rdy: got %b want 0", cmd_rdy); end
        checks++; if (clr_cmd_rdy_UART !== 1'b0) begin errors++; $display("FAIL reset clr_uart: got %b want 0", clr_cmd_rdy_UART); end
        checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL reset resp: got %h want a5", resp); end
        checks++; if (mv_indx !== '0) begin errors++; $display("FAIL reset mv_indx: got %0d want 0", mv_indx); end
    endtask

    task automatic test_uart_passthrough();
        @(negedge clk);
        cmd_UART = 16'h2000;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy = 1'b1;
        #1;
        checks++; if (cmd !== 16'h2000) begin errors++; $display("FAIL uart cmd: got %h want 2000", cmd); end
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL uart cmd_rdy: got %b want 1", cmd_rdy); end
        checks++; if (clr_cmd_rdy_UART !== 1'b1) begin errors++; $display("FAIL uart clr: got %b want 1", clr_cmd_rdy_UART); end
        checks++; if (resp !== 8'hA5) begin errors++; $display("FAIL uart resp: got %h want a5", resp); end
        checks++; if (mv_indx !== '0) begin errors++; $display("FAIL uart mv_indx: got %0d want 0", mv_indx); end
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_single_move();
        fill_table(1'b0, 8'h01);
        pulse_start();
        checks++; if (cmd !== 16'h4002 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL single vert: got %h/%b want 4002/1", cmd, cmd_rdy); end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL single wait_v rdy: got %b want 0", cmd_rdy); end
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        checks++; if (cmd !== 16'h5BF1 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL single horz: got %h/%b want 5bf1/1", cmd, cmd_rdy); end
        checks++; if (resp !== 8'h5A) begin errors++; $display("FAIL single resp: got %h want 5a", resp); end
        do_reset();
    endtask

    task automatic test_full_tour();
        fill_table(1'b1, 8'h00);
        cmd_UART = 16'hBEEF;
        cmd_rdy_UART = 1'b1;
        for (int i = 0; i < NUM_MOVES; i++) push_move(tbl[i]);
        leak = 0;
        pulse_start();
        mon_en = 1'b1;
        checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL tour latency: got cmd_rdy=%b want 1", cmd_rdy); end
        for (int i = 0; i < NUM_MOVES; i++) begin
            serve_leg("tour_v", IDX_W'(i), 8'h5A);
            serve_leg("tour_h", IDX_W'(i), (i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A);
        end
        mon_en = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tour count: got %0d leftover want 0", exp_q.size()); end
        checks++; if (leak != 0) begin errors++; $display("FAIL tour clr_uart_leak: got %0d want 0", leak); end
        checks++; if (cmd !== 16'hBEEF || cmd_rdy !== 1'b1 || resp !== 8'hA5) begin
            errors++; $display("FAIL tour back_to_uart: got %h/%b/%h want beef/1/a5", cmd, cmd_rdy, resp); end
        cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_handshake_abuse();
        fill_table(1'b1, 8'h00);
        cmd_rdy_UART = 1'b1;
        push_move(tbl[0]);
        leak = 0;
        pulse_start();
        mon_en = 1'b1;
        serve_leg("abuse_v0", '0, 8'h5A);
        serve_leg("abuse_h0", '0, 8'h5A);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        checks++; if (cmd_rdy !== 1'b1 || cmd !== model_cmd(tbl[1], 1'b0) || mv_indx !== 5'd1) begin
            errors++; $display("FAIL abuse send_in_vert: got %h/%b/%0d want %h/1/1", cmd, cmd_rdy, mv_indx, model_cmd(tbl[1], 1'b0)); end
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        checks++; if (cmd_rdy !== 1'b1 || mv_indx !== 5'd1) begin
            errors++; $display("FAIL abuse start_mid: got rdy=%b idx=%0d want 1/1", cmd_rdy, mv_indx); end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        checks++; if (cmd_rdy !== 1'b0 || cmd !== model_cmd(tbl[1], 1'b0)) begin
            errors++; $display("FAIL abuse clr_in_wait_v: got %h/%b want %h/0", cmd, cmd_rdy, model_cmd(tbl[1], 1'b0)); end
        clr_cmd_rdy = 1'b1;
        send_resp = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        checks++; if (cmd_rdy !== 1'b1 || cmd !== model_cmd(tbl[1], 1'b1) || mv_indx !== 5'd1) begin
            errors++; $display("FAIL abuse both_in_wait_v: got %h/%b/%0d want %h/1/1", cmd, cmd_rdy, mv_indx, model_cmd(tbl[1], 1'b1)); end
        mon_en = 1'b0;
        checks++; if (leak != 0) begin errors++; $display("FAIL abuse clr_uart_leak: got %0d want 0", leak); end
        do_reset();
    endtask

    task automatic test_reset_mid_tour();
        fill_table(1'b1, 8'h00);
        cmd_rdy_UART = 1'b1;
        for (int i = 0; i < 8; i++) push_move(tbl[i]);
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            serve_leg("mid_v", IDX_W'(i), 8'h5A);
            serve_leg("mid_h", IDX_W'(i), 8'h5A);
        end
        serve_leg("mid_v7", 5'd7, 8'h5A);
        checks++; if (cmd_rdy !== 1'b1 || cmd !== model_cmd(tbl[7], 1'b1) || mv_indx !== 5'd7) begin
            errors++; $display("FAIL mid horz7: got %h/%b/%0d want %h/1/7", cmd, cmd_rdy, mv_indx, model_cmd(tbl[7], 1'b1)); end
        cmd_rdy_UART = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (mv_indx !== '0 || cmd_rdy !== 1'b0 || resp !== 8'hA5 || clr_cmd_rdy_UART !== 1'b0) begin
            errors++; $display("FAIL mid reset: got idx=%0d rdy=%b resp=%h clr=%b want 0/0/a5/0", mv_indx, cmd_rdy, resp, clr_cmd_rdy_UART); end
        rst_n = 1'b1;
        exp_q.delete();
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b1;
        #1;
        checks++; if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
            errors++; $display("FAIL mid uart_restored: got %h/%b want 1234/1", cmd, cmd_rdy); end
        pulse_start();
        checks++; if (mv_indx !== '0 || cmd_rdy !== 1'b1 || cmd !== model_cmd(tbl[0], 1'b0)) begin
            errors++; $display("FAIL mid restart: got %h/%b/%0d want %h/1/0", cmd, cmd_rdy, mv_indx, model_cmd(tbl[0], 1'b0)); end
        cmd_rdy_UART = 1'b0;
        do_reset();
    endtask

    task automatic test_bad_moves();
        fill_table(1'b0, 8'h00);
        push_move(8'h00);
        pulse_start();
        serve_leg("bad00_v", '0, 8'h5A);
        serve_leg("bad00_h", '0, 8'h5A);
        do_reset();
        fill_table(1'b0, 8'h0C);
        push_move(8'h0C);
        pulse_start();
        serve_leg("bad0c_v", '0, 8'h5A);
        serve_leg("bad0c_h", '0, 8'h5A);
        do_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        start_tour = 1'b0;
        cmd_UART = 16'h0000;
        cmd_rdy_UART = 1'b0;
        clr_cmd_rdy = 1'b0;
        send_resp = 1'b0;
        fill_table(1'b0, 8'h00);
        test_reset();
        test_uart_passthrough();
        test_single_move();
        test_full_tour();
        test_handshake_abuse();
        test_reset_mid_tour();
        test_bad_moves();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
